// File: rtl/three_input_gate_arbiter_v.sv
// Round-robin arbiter that shares one programmable three-input gate among N_REQ
// requesters and returns each registered result tagged with its requester ID.
module three_input_gate_arbiter_v #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ-1:0]   i_req_a,
  input  logic [N_REQ-1:0]   i_req_b,
  input  logic [N_REQ-1:0]   i_req_c,
  input  logic [2*N_REQ-1:0] i_req_code,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic               o_rsp_f,
  output logic [ID_W-1:0]    o_rsp_id,
  output logic               o_busy
);

  typedef enum logic {EMPTY, FULL} slot_state_t;

  slot_state_t     state, state_next;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic            found;
  logic            can_load;
  logic            grant;
  logic            gnt_f;

  function automatic logic gate_fn(input logic a, input logic b, input logic c,
                                   input logic [1:0] code);
    case (code)
      2'b00:   gate_fn = a ^ b ^ c;
      2'b01:   gate_fn = ~(a & b & c);
      2'b10:   gate_fn = ~(a | b | c);
      default: gate_fn = ~(a ^ b ^ c);
    endcase
  endfunction

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && i_req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

  // Reset is folded in so ready stays low while the slot is held in reset.
  assign can_load    = (state == EMPTY) || (state == FULL && i_rsp_ready);
  assign grant       = found && can_load && i_rst_n;
  assign o_req_ready = grant ? (N_REQ'(1) << gnt_id) : '0;
  assign gnt_f       = gate_fn(i_req_a[gnt_id], i_req_b[gnt_id], i_req_c[gnt_id],
                               i_req_code[2*gnt_id +: 2]);

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (grant) state_next = FULL;
      FULL:    if (i_rsp_ready && !grant) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= EMPTY;
      ptr      <= '0;
      o_rsp_f  <= 1'b0;
      o_rsp_id <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        o_rsp_f  <= gnt_f;
        o_rsp_id <= gnt_id;
        ptr      <= (int'(gnt_id) == N_REQ-1) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  assign o_rsp_valid = (state == FULL);
  assign o_busy      = (|i_req_valid) || o_rsp_valid;

endmodule

// File: tb/tb_three_input_gate_arbiter_v.sv
// Directed, table-driven bench for three_input_gate_arbiter_v with N_REQ=4,
// plus hand-written reset and busy sequences.
module tb_three_input_gate_arbiter_v;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [3:0] i_req_valid, i_req_a, i_req_b, i_req_c;
  logic [7:0] i_req_code;
  logic [3:0] o_req_ready;
  logic       o_rsp_valid, i_rsp_ready, o_rsp_f, o_busy;
  logic [1:0] o_rsp_id;

  int compared   = 0;
  int mismatched = 0;

  three_input_gate_arbiter_v #(.N_REQ(4), .ID_W(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid),
    .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_c(i_req_c),
    .i_req_code(i_req_code), .o_req_ready(o_req_ready),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_f(o_rsp_f), .o_rsp_id(o_rsp_id), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] valid, a, b, c;
    logic [7:0] code;
    logic       rdy;
    logic [3:0] exp_ready;
    logic       exp_valid, exp_f;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic [3:0] valid, logic [3:0] a, logic [3:0] b,
                              logic [3:0] c, logic [7:0] code, logic rdy,
                              logic [3:0] er, logic ev, logic ef, logic [1:0] eid);
    vec_t v;
    v.valid = valid; v.a = a; v.b = b; v.c = c; v.code = code; v.rdy = rdy;
    v.exp_ready = er; v.exp_valid = ev; v.exp_f = ef; v.exp_id = eid;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive at negedge, check ready before the rising edge, check response after it.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge i_clk);
    i_req_valid = v.valid; i_req_a = v.a; i_req_b = v.b; i_req_c = v.c;
    i_req_code  = v.code;  i_rsp_ready = v.rdy;
    #2;
    checkOutput({tag, " ready"}, 8'(o_req_ready), 8'(v.exp_ready));
    @(posedge i_clk);
    #1;
    checkOutput({tag, " rsp_valid"}, 8'(o_rsp_valid), 8'(v.exp_valid));
    if (v.exp_valid) begin
      checkOutput({tag, " rsp_f"}, 8'(o_rsp_f), 8'(v.exp_f));
      checkOutput({tag, " rsp_id"}, 8'(o_rsp_id), 8'(v.exp_id));
    end
  endtask

  localparam logic [3:0] RA = 4'b0101, RB = 4'b0011, RC = 4'b0000;
  localparam logic [7:0] RCODE = 8'b11_10_01_00;

  initial begin
    // Requester 0 with a=1,b=0,c=1 through all four codes.
    vecs[0]  = mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'h00, 1'b1, 4'b0001, 1, 0, 0);
    vecs[1]  = mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'h01, 1'b1, 4'b0001, 1, 1, 0);
    vecs[2]  = mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'h02, 1'b1, 4'b0001, 1, 0, 0);
    vecs[3]  = mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'h03, 1'b1, 4'b0001, 1, 1, 0);
    vecs[4]  = mk(4'b0000, RA, RB, RC, RCODE, 1'b1, 4'b0000, 0, 0, 0);
    // Move ptr to 0 via requester 3, then all four valid.
    vecs[5]  = mk(4'b1000, RA, RB, RC, RCODE, 1'b1, 4'b1000, 1, 1, 3);
    vecs[6]  = mk(4'b1111, RA, RB, RC, RCODE, 1'b1, 4'b0001, 1, 0, 0);
    vecs[7]  = mk(4'b1111, RA, RB, RC, RCODE, 1'b1, 4'b0010, 1, 1, 1);
    vecs[8]  = mk(4'b1111, RA, RB, RC, RCODE, 1'b1, 4'b0100, 1, 0, 2);
    vecs[9]  = mk(4'b1111, RA, RB, RC, RCODE, 1'b1, 4'b1000, 1, 1, 3);
    vecs[10] = mk(4'b1111, RA, RB, RC, RCODE, 1'b1, 4'b0001, 1, 0, 0);
    vecs[11] = mk(4'b1111, RA, RB, RC, RCODE, 1'b1, 4'b0010, 1, 1, 1);
    // ptr=2 with only 1 and 3 valid: wrap and skip.
    vecs[12] = mk(4'b1010, RA, RB, RC, RCODE, 1'b1, 4'b1000, 1, 1, 3);
    vecs[13] = mk(4'b1010, RA, RB, RC, RCODE, 1'b1, 4'b0010, 1, 1, 1);
    vecs[14] = mk(4'b1010, RA, RB, RC, RCODE, 1'b1, 4'b1000, 1, 1, 3);
    // Stall three cycles, then FULL->FULL reload from requester 2.
    vecs[15] = mk(4'b0100, RA, RB, RC, RCODE, 1'b0, 4'b0000, 1, 1, 3);
    vecs[16] = mk(4'b0100, RA, RB, RC, RCODE, 1'b0, 4'b0000, 1, 1, 3);
    vecs[17] = mk(4'b0100, RA, RB, RC, RCODE, 1'b0, 4'b0000, 1, 1, 3);
    vecs[18] = mk(4'b0100, RA, RB, RC, RCODE, 1'b1, 4'b0100, 1, 0, 2);
    // Drain with nothing valid; ptr must still be 3 afterwards.
    vecs[19] = mk(4'b0000, RA, RB, RC, RCODE, 1'b1, 4'b0000, 0, 0, 0);
    vecs[20] = mk(4'b1111, RA, RB, RC, RCODE, 1'b1, 4'b1000, 1, 1, 3);

    i_rst_n = 1'b0; i_req_valid = '0; i_req_a = '0; i_req_b = '0; i_req_c = '0;
    i_req_code = '0; i_rsp_ready = 1'b0;
    #12;
    checkOutput("reset rsp_valid", 8'(o_rsp_valid), 8'd0);
    checkOutput("reset rsp_f", 8'(o_rsp_f), 8'd0);
    checkOutput("reset rsp_id", 8'(o_rsp_id), 8'd0);
    checkOutput("reset busy", 8'(o_busy), 8'd0);
    i_req_valid = 4'b0100;
    #1;
    checkOutput("reset ready", 8'(o_req_ready), 8'd0);
    checkOutput("reset busy follows valid", 8'(o_busy), 8'd1);
    @(negedge i_clk);
    i_req_valid = '0;
    i_rst_n = 1'b1;

    for (int i = 0; i < 21; i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // ptr=0 now; load requester 2 with NAND(1,0,0)=1 and hold it.
    applyStimulus(mk(4'b0100, RA, RB, RC, 8'b11_01_01_00, 1'b1, 4'b0100, 1, 1, 2),
                  "load id2");
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    #1;
    checkOutput("busy while FULL", 8'(o_busy), 8'd1);
    #1;
    i_rst_n = 1'b0;
    #1;
    checkOutput("midreset rsp_valid", 8'(o_rsp_valid), 8'd0);
    checkOutput("midreset rsp_f", 8'(o_rsp_f), 8'd0);
    checkOutput("midreset rsp_id", 8'(o_rsp_id), 8'd0);
    checkOutput("midreset ready", 8'(o_req_ready), 8'd0);
    #1;
    i_rst_n = 1'b1;
    applyStimulus(mk(4'b0110, RA, RB, RC, RCODE, 1'b1, 4'b0010, 1, 1, 1), "post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
